frame_head_gen_mc: RTL and testbench
====================================

# frame_head_gen_mc

Multi-channel, parametrised frame-header generator. It sits ahead of the per-channel data FIFOs in the SSD write path and emits byte-serial headers for each enabled channel in round-robin order. Each header is a sync code, then a per-channel frame counter, then an optional reserved byte. Sync length, counter length, step and channel set are configured through a latched update handshake. Each channel keeps an independent frame counter, and back-pressure is taken per channel.

## Interface
Parameters:
- SYNC_MAX, 10, maximum sync-code bytes.
- CNTR_MAX, 6, maximum frame-counter bytes.
- NCH, 4, number of channels (2..16).
- CH_W, 2, channel index width; must satisfy 2^CH_W >= NCH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- update_flag  in  1  level config-update request.
- sync_code_length  in  4  sync bytes to send.
- sync_code_content  in  8*SYNC_MAX  sync code, right-aligned (byte 0 = LSB).
- cntr_length  in  4  counter bytes to send.
- cntr_init  in  8*CNTR_MAX  initial value loaded into every channel counter.
- cntr_step  in  8  per-header counter increment, zero-extended.
- res_flag  in  1  append reserved byte.
- res_content  in  8  reserved byte value.
- chan_enable  in  NCH  channels taking part in arbitration.
- fifo_full_h  in  NCH  per-channel almost-full, registered internally.
- dat_out  out  8  header byte.
- en_out  out  1  dat_out valid.
- ch_out  out  CH_W  channel owning the current byte.
- sof_out  out  1  high with the first byte of each header.
- busy  out  1  FSM not in IDLE.

## Operation
- update_flag passes through two registers, upd0 then upd1.
- Rising edge (upd0 & ~upd1): latch all config inputs and load every channel counter with cntr_init.
- Lengths are clamped on latch: sync_len = min(input, SYNC_MAX); cntr_len = min(input, CNTR_MAX).
- While upd0 = 1: FSM forced to IDLE, en_out low next cycle, round-robin pointer cleared to 0.
- Falling edge (upd1 & ~upd0): IDLE→ARB, provided latched chan_enable ≠ 0 and sync_len + cntr_len + res_flag > 0. Otherwise stay in IDLE.
- FSM states:
  - IDLE
  - ARB
  - SYNC
  - CNTR
  - RES
  - GAP
- ARB picks the first channel, searching upward with wrap from (last granted + 1), that is enabled and has registered fifo_full_h = 0. If there is no candidate, it stays in ARB. After the grant it enters the first non-empty field state.
- SYNC sends the low sync_len bytes of the sync code, most significant first.
- CNTR sends the low cntr_len bytes of the granted channel's counter, most significant first.
- RES sends res_content; it is only entered if res_flag = 1.
- Once granted, a header is atomic: fifo_full_h changes do not interrupt it.
- On the last header byte, the granted channel's counter += cntr_step, modulo 2^(8*CNTR_MAX); the value sent wraps modulo 2^(8*cntr_len). Other channels' counters are unchanged.
- GAP lasts exactly 1 cycle with en_out low, then returns to ARB.
- Outputs are registered one stage after the FSM data register.

## Timing
- Reset values: dat_out = 0, en_out = 0, ch_out = 0, sof_out = 0, busy = 0. State is IDLE, all counters 0, config registers 0, pointer 0.
- Config latch: update_flag rising at cycle T → config latched at the T+2 edge.
- Start: update_flag falling at cycle F → ARB at F+2, first header byte on dat_out at F+4, provided a channel is ready.
- Within a header, bytes are on consecutive cycles with no bubbles.
- Between headers there are at least 2 en_out-low cycles: GAP + ARB.
- fifo_full_h is registered: a channel asserting full at cycle C is excluded from grants decided at C+1 onward.
- reset_n low mid-header: all outputs are at their reset values on the next edge. The header is truncated and not resumed.
- update_flag asserted mid-header: the header is truncated, and en_out goes low 2 cycles after assertion.

## Test plan
- Single channel: NCH = 4, chan_enable = 0001, sync 3 bytes = 0xEB90AA, cntr_len = 2, init = 0x0005, step = 1, res_flag = 0 → stream EB 90 AA 00 05, gap, EB 90 AA 00 06. sof_out is high on each EB.
- Round-robin with reserved byte: chan_enable = 1011, res = 0x5A → ch_out sequence 0, 1, 3, 0, 1, 3. Each channel's counter starts at the init value and increments independently. Each header ends with 5A.
- Back-pressure: hold fifo_full_h[1] = 1 throughout → channel 1 is never granted while 0 and 3 keep alternating. Raise fifo_full_h[0] mid-header on channel 0 → that header still completes.
- Clamp and wrap: sync_len = 12 → exactly 10 sync bytes sent. cntr_len = 1, init = 0xFE, step = 1 → counter bytes FE, FF, 00.
- Update mid-header: pulse update_flag during a CNTR byte → en_out low within 2 cycles. After release, the new config is used and counters restart from the new cntr_init.
- Degenerate config: sync_len = 0, cntr_len = 0, res_flag = 0, or chan_enable = 0 → busy stays 0 and en_out is never asserted.

Source files
------------

// File: rtl/frame_head_gen_mc.sv
// Multi-channel frame-header generator: round-robin byte-serial headers
// (sync code, per-channel frame counter, optional reserved byte).
`timescale 1ns/1ps
module frame_head_gen_mc #(
    parameter int unsigned SYNC_MAX = 10,
    parameter int unsigned CNTR_MAX = 6,
    parameter int unsigned NCH      = 4,
    parameter int unsigned CH_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    update_flag,
    input  logic [3:0]              sync_code_length,
    input  logic [8*SYNC_MAX-1:0]   sync_code_content,
    input  logic [3:0]              cntr_length,
    input  logic [8*CNTR_MAX-1:0]   cntr_init,
    input  logic [7:0]              cntr_step,
    input  logic                    res_flag,
    input  logic [7:0]              res_content,
    input  logic [NCH-1:0]          chan_enable,
    input  logic [NCH-1:0]          fifo_full_h,
    output logic [7:0]              dat_out,
    output logic                    en_out,
    output logic [CH_W-1:0]         ch_out,
    output logic                    sof_out,
    output logic                    busy
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CW    = 8 * CNTR_MAX;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARB, ST_SYNC, ST_CNTR, ST_RES, ST_GAP
    } state_t;

    logic                  r_upd0, r_upd1;
    logic [LEN_W-1:0]      r_sync_len, r_cntr_len;
    logic [8*SYNC_MAX-1:0] r_sync;
    logic [7:0]            r_step, r_res;
    logic                  r_res_flag;
    logic [NCH-1:0]        r_chen, r_full;
    logic [CW-1:0]         r_cnt [NCH];
    state_t                r_state;
    logic [LEN_W-1:0]      r_idx;
    logic [CH_W-1:0]       r_ch, r_ptr;
    logic [7:0]            r_d_dat;
    logic                  r_d_en, r_d_sof;
    logic [CH_W-1:0]       r_d_ch;
    logic [7:0]            r_dat_out;
    logic                  r_en_out, r_sof_out, r_busy;
    logic [CH_W-1:0]       r_ch_out;

    logic [NCH-1:0]        w_cand;
    logic                  w_found;
    logic [CH_W-1:0]       w_gnt, w_bch;
    state_t                w_after_cntr, w_after_sync, w_start, w_nxt_st;
    logic [LEN_W-1:0]      w_nxt_idx, w_sync_k, w_cntr_k;
    logic [7:0]            w_byte;
    logic                  w_cfg_ok;

    assign dat_out = r_dat_out;
    assign en_out  = r_en_out;
    assign ch_out  = r_ch_out;
    assign sof_out = r_sof_out;
    assign busy    = r_busy;

    assign w_cand   = r_chen & ~r_full;
    assign w_cfg_ok = (r_chen != '0) &&
                      ((r_sync_len != '0) || (r_cntr_len != '0) || r_res_flag);

    // Round-robin search upward from the pointer, wrapping at NCH
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (!w_found && (c == (int'(r_ptr) + i) % int'(NCH)) && w_cand[c]) begin
                    w_found = 1'b1;
                    w_gnt   = CH_W'(c);
                end
            end
        end
    end

    // Next header byte position; empty fields are skipped
    always_comb begin
        w_after_cntr = r_res_flag ? ST_RES : ST_GAP;
        w_after_sync = (r_cntr_len != '0) ? ST_CNTR : w_after_cntr;
        w_start      = (r_sync_len != '0) ? ST_SYNC : w_after_sync;
        w_nxt_st     = ST_GAP;
        w_nxt_idx    = '0;
        case (r_state)
            ST_ARB:  w_nxt_st = w_start;
            ST_SYNC: begin
                if (r_idx + LEN_W'(1) < r_sync_len) begin
                    w_nxt_st  = ST_SYNC;
                    w_nxt_idx = r_idx + LEN_W'(1);
                end else begin
                    w_nxt_st = w_after_sync;
                end
            end
            ST_CNTR: begin
                if (r_idx + LEN_W'(1) < r_cntr_len) begin
                    w_nxt_st  = ST_CNTR;
                    w_nxt_idx = r_idx + LEN_W'(1);
                end else begin
                    w_nxt_st = w_after_cntr;
                end
            end
            default: w_nxt_st = ST_GAP;
        endcase
    end

    // Byte value at the next position, most significant byte first
    always_comb begin
        w_bch    = (r_state == ST_ARB) ? w_gnt : r_ch;
        w_sync_k = r_sync_len - w_nxt_idx - LEN_W'(1);
        w_cntr_k = r_cntr_len - w_nxt_idx - LEN_W'(1);
        w_byte   = '0;
        case (w_nxt_st)
            ST_SYNC: begin
                for (int b = 0; b < int'(SYNC_MAX); b++)
                    if (LEN_W'(b) == w_sync_k) w_byte = r_sync[8*b +: 8];
            end
            ST_CNTR: begin
                for (int c = 0; c < int'(NCH); c++)
                    for (int b = 0; b < int'(CNTR_MAX); b++)
                        if ((CH_W'(c) == w_bch) && (LEN_W'(b) == w_cntr_k))
                            w_byte = r_cnt[c][8*b +: 8];
            end
            ST_RES:  w_byte = r_res;
            default: w_byte = '0;
        endcase
    end

    // Update synchroniser, config latch, counters and header FSM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_upd0     <= 1'b0;
            r_upd1     <= 1'b0;
            r_full     <= '0;
            r_sync_len <= '0;
            r_cntr_len <= '0;
            r_sync     <= '0;
            r_step     <= '0;
            r_res      <= '0;
            r_res_flag <= 1'b0;
            r_chen     <= '0;
            for (int c = 0; c < int'(NCH); c++) r_cnt[c] <= '0;
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_ch       <= '0;
            r_ptr      <= '0;
            r_d_dat    <= '0;
            r_d_en     <= 1'b0;
            r_d_sof    <= 1'b0;
            r_d_ch     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_upd0  <= update_flag;
            r_upd1  <= r_upd0;
            r_full  <= fifo_full_h;
            r_d_en  <= 1'b0;
            r_d_sof <= 1'b0;
            r_d_dat <= '0;
            if (r_upd0) begin
                r_state <= ST_IDLE;
                r_ptr   <= '0;
                r_busy  <= 1'b0;
                if (!r_upd1) begin
                    r_sync_len <= (sync_code_length > LEN_W'(SYNC_MAX)) ?
                                  LEN_W'(SYNC_MAX) : sync_code_length;
                    r_cntr_len <= (cntr_length > LEN_W'(CNTR_MAX)) ?
                                  LEN_W'(CNTR_MAX) : cntr_length;
                    r_sync     <= sync_code_content;
                    r_step     <= cntr_step;
                    r_res      <= res_content;
                    r_res_flag <= res_flag;
                    r_chen     <= chan_enable;
                    for (int c = 0; c < int'(NCH); c++) r_cnt[c] <= cntr_init;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_upd1 && w_cfg_ok) begin
                            r_state <= ST_ARB;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_ARB: begin
                        if (w_found) begin
                            r_ch    <= w_gnt;
                            r_ptr   <= (w_gnt == CH_W'(NCH - 1)) ? '0 : w_gnt + CH_W'(1);
                            r_state <= w_nxt_st;
                            r_idx   <= w_nxt_idx;
                            r_d_en  <= 1'b1;
                            r_d_sof <= 1'b1;
                            r_d_dat <= w_byte;
                            r_d_ch  <= w_gnt;
                        end
                    end
                    ST_SYNC, ST_CNTR, ST_RES: begin
                        r_state <= w_nxt_st;
                        r_idx   <= w_nxt_idx;
                        if (w_nxt_st == ST_GAP) begin
                            for (int c = 0; c < int'(NCH); c++)
                                if (CH_W'(c) == r_ch) r_cnt[c] <= r_cnt[c] + CW'(r_step);
                        end else begin
                            r_d_en  <= 1'b1;
                            r_d_dat <= w_byte;
                            r_d_ch  <= r_ch;
                        end
                    end
                    ST_GAP:  r_state <= ST_ARB;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output stage; an update request blanks the stream immediately
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dat_out <= '0;
            r_en_out  <= 1'b0;
            r_sof_out <= 1'b0;
            r_ch_out  <= '0;
        end else if (r_upd0) begin
            r_dat_out <= '0;
            r_en_out  <= 1'b0;
            r_sof_out <= 1'b0;
        end else begin
            r_dat_out <= r_d_dat;
            r_en_out  <= r_d_en;
            r_sof_out <= r_d_sof;
            r_ch_out  <= r_d_ch;
        end
    end

endmodule

// File: tb/tb_frame_head_gen_mc.sv
// Scoreboard bench for frame_head_gen_mc: expected header bytes are queued
// as configs are applied and checked as the DUT emits them.
`timescale 1ns/1ps
module tb_frame_head_gen_mc;

    localparam int unsigned SYNC_MAX = 10;
    localparam int unsigned CNTR_MAX = 6;
    localparam int unsigned NCH      = 4;
    localparam int unsigned CH_W     = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  update_flag;
    logic [3:0]            sync_code_length;
    logic [8*SYNC_MAX-1:0] sync_code_content;
    logic [3:0]            cntr_length;
    logic [8*CNTR_MAX-1:0] cntr_init;
    logic [7:0]            cntr_step;
    logic                  res_flag;
    logic [7:0]            res_content;
    logic [NCH-1:0]        chan_enable;
    logic [NCH-1:0]        fifo_full_h;
    logic [7:0]            dat_out;
    logic                  en_out;
    logic [CH_W-1:0]       ch_out;
    logic                  sof_out;
    logic                  busy;

    typedef struct packed {
        logic            sof;
        logic [CH_W-1:0] ch;
        logic [7:0]      dat;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_popped = 0;
    int   low_run  = 100;
    logic prev_en  = 1'b0;

    frame_head_gen_mc #(
        .SYNC_MAX(SYNC_MAX), .CNTR_MAX(CNTR_MAX), .NCH(NCH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .update_flag(update_flag),
        .sync_code_length(sync_code_length), .sync_code_content(sync_code_content),
        .cntr_length(cntr_length), .cntr_init(cntr_init), .cntr_step(cntr_step),
        .res_flag(res_flag), .res_content(res_content), .chan_enable(chan_enable),
        .fifo_full_h(fifo_full_h), .dat_out(dat_out), .en_out(en_out),
        .ch_out(ch_out), .sof_out(sof_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output monitor: pop and compare every emitted byte, check spacing
    always @(negedge clk) begin
        exp_t e, got;
        if (en_out) begin
            got = '{sof: sof_out, ch: ch_out, dat: dat_out};
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_byte got sof=%0d ch=%0d dat=%02h expected no byte",
                       sof_out, ch_out, dat_out);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_tests++;
                assert (got === e) else begin
                    n_fail++;
                    $error("FAIL byte#%0d got sof=%0d ch=%0d dat=%02h expected sof=%0d ch=%0d dat=%02h",
                           n_popped, got.sof, got.ch, got.dat, e.sof, e.ch, e.dat);
                end
                n_tests++;
                assert (e.sof ? (low_run >= 2) : prev_en) else begin
                    n_fail++;
                    $error("FAIL spacing byte#%0d got low_run=%0d prev_en=%0d expected sof:>=2 idle / body:no bubble",
                           n_popped, low_run, prev_en);
                end
            end
            n_popped++;
            low_run = 0;
        end else if (low_run < 100) begin
            low_run++;
        end
        prev_en = en_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_hdr(input logic [CH_W-1:0] ch, input int slen, input logic [79:0] sync,
                            input int clen, input logic [47:0] cval,
                            input logic rf, input logic [7:0] rv);
        logic first;
        first = 1'b1;
        for (int i = slen - 1; i >= 0; i--) begin
            q.push_back('{sof: first, ch: ch, dat: sync[8*i +: 8]});
            first = 1'b0;
        end
        for (int i = clen - 1; i >= 0; i--) begin
            q.push_back('{sof: first, ch: ch, dat: cval[8*i +: 8]});
            first = 1'b0;
        end
        if (rf) q.push_back('{sof: first, ch: ch, dat: rv});
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_popped < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_tests++;
        assert (n_popped >= target) else begin
            n_fail++;
            $error("FAIL %s timeout got popped=%0d expected %0d", tag, n_popped, target);
        end
    endtask

    task automatic set_cfg(input logic [3:0] sl, input logic [79:0] sc, input logic [3:0] cl,
                           input logic [47:0] ci, input logic [7:0] st, input logic rf,
                           input logic [7:0] rc, input logic [3:0] ce);
        sync_code_length  = sl;
        sync_code_content = sc;
        cntr_length       = cl;
        cntr_init         = ci;
        cntr_step         = st;
        res_flag          = rf;
        res_content       = rc;
        chan_enable       = ce;
    endtask

    // Latch a config with a 3-cycle update pulse; release lands on a negedge
    task automatic apply_cfg(input logic [3:0] sl, input logic [79:0] sc, input logic [3:0] cl,
                             input logic [47:0] ci, input logic [7:0] st, input logic rf,
                             input logic [7:0] rc, input logic [3:0] ce);
        set_cfg(sl, sc, cl, ci, st, rf, rc, ce);
        update_flag = 1'b1;
        repeat (3) @(negedge clk);
        update_flag = 1'b0;
    endtask

    // Park the DUT by latching a config with no channels enabled
    task automatic park(input string tag);
        apply_cfg(4'd0, '0, 4'd0, '0, 8'd0, 1'b0, 8'd0, 4'b0000);
        repeat (3) @(negedge clk);
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic watch_idle(input string tag);
        logic any_busy, any_en;
        any_busy = 1'b0;
        any_en   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_busy |= busy;
            any_en   |= en_out;
        end
        chk({tag, "_busy"}, 32'(any_busy), 32'd0);
        chk({tag, "_en"},   32'(any_en),   32'd0);
    endtask

    initial begin
        int   base;
        int   uses [NCH];
        logic [1:0] rr [6];

        reset_n     = 1'b0;
        update_flag = 1'b0;
        fifo_full_h = '0;
        set_cfg(4'd0, '0, 4'd0, '0, 8'd0, 1'b0, 8'd0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("rst_dat",  32'(dat_out), 32'd0);
        chk("rst_en",   32'(en_out),  32'd0);
        chk("rst_ch",   32'(ch_out),  32'd0);
        chk("rst_sof",  32'(sof_out), 32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single channel, start latency, counter increments 5,6,7
        base = n_popped;
        for (int h = 0; h < 3; h++)
            push_hdr(2'd0, 3, 80'hEB90AA, 2, 48'(5 + h), 1'b0, 8'h00);
        apply_cfg(4'd3, 80'hEB90AA, 4'd2, 48'h5, 8'd1, 1'b0, 8'h00, 4'b0001);
        repeat (3) begin
            @(negedge clk);
            chk("start_lat_low", 32'(en_out), 32'd0);
        end
        @(negedge clk);
        chk("start_lat_first", 32'(en_out), 32'd1);
        chk("busy_active", 32'(busy), 32'd1);
        wait_pops(base + 15, 200, "single");
        park("single");

        // Round-robin over channels 0,1,3 with reserved byte
        base = n_popped;
        rr[0] = 2'd0; rr[1] = 2'd1; rr[2] = 2'd3; rr[3] = 2'd0; rr[4] = 2'd1; rr[5] = 2'd3;
        for (int c = 0; c < int'(NCH); c++) uses[c] = 0;
        for (int h = 0; h < 6; h++) begin
            push_hdr(rr[h], 2, 80'h1234, 2, 48'(32'h100 + 3 * uses[rr[h]]), 1'b1, 8'h5A);
            uses[rr[h]]++;
        end
        apply_cfg(4'd2, 80'h1234, 4'd2, 48'h100, 8'd3, 1'b1, 8'h5A, 4'b1011);
        wait_pops(base + 30, 300, "roundrobin");
        park("roundrobin");

        // Back-pressure: ch1 always full; ch0 goes full during its second header
        base = n_popped;
        fifo_full_h = 4'b0010;
        push_hdr(2'd0, 2, 80'h1234, 2, 48'h100, 1'b1, 8'h5A);
        push_hdr(2'd3, 2, 80'h1234, 2, 48'h100, 1'b1, 8'h5A);
        push_hdr(2'd0, 2, 80'h1234, 2, 48'h103, 1'b1, 8'h5A);
        push_hdr(2'd3, 2, 80'h1234, 2, 48'h103, 1'b1, 8'h5A);
        push_hdr(2'd3, 2, 80'h1234, 2, 48'h106, 1'b1, 8'h5A);
        apply_cfg(4'd2, 80'h1234, 4'd2, 48'h100, 8'd3, 1'b1, 8'h5A, 4'b1011);
        wait_pops(base + 11, 200, "bp_mid");
        fifo_full_h = 4'b0011;
        wait_pops(base + 25, 300, "backpressure");
        park("backpressure");
        fifo_full_h = '0;

        // Sync length clamps to 10; 1-byte counter wraps FE, FF, 00
        base = n_popped;
        for (int h = 0; h < 3; h++)
            push_hdr(2'd0, 10, 80'h19181716151413121110, 1, 48'(32'hFE + h), 1'b0, 8'h00);
        apply_cfg(4'd12, 80'h19181716151413121110, 4'd1, 48'hFE, 8'd1, 1'b0, 8'h00, 4'b0001);
        wait_pops(base + 33, 300, "clamp_wrap");
        park("clamp_wrap");

        // Update during the first counter byte truncates; new init takes over
        base = n_popped;
        push_hdr(2'd0, 3, 80'hEB90AA, 2, 48'h5, 1'b0, 8'h00);
        apply_cfg(4'd3, 80'hEB90AA, 4'd2, 48'h5, 8'd1, 1'b0, 8'h00, 4'b0001);
        wait_pops(base + 3, 100, "upd_pre");
        set_cfg(4'd3, 80'hEB90AA, 4'd2, 48'h200, 8'd1, 1'b0, 8'h00, 4'b0001);
        update_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("upd_trunc_en", 32'(en_out), 32'd0);
        chk("upd_trunc_left", 32'(q.size()), 32'd1);
        q.delete();
        for (int h = 0; h < 3; h++)
            push_hdr(2'd0, 3, 80'hEB90AA, 2, 48'(32'h200 + h), 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        update_flag = 1'b0;
        base = n_popped;
        wait_pops(base + 12, 200, "upd_new");

        // Reset in the middle of the third header
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_dat",  32'(dat_out), 32'd0);
        chk("midrst_en",   32'(en_out),  32'd0);
        chk("midrst_ch",   32'(ch_out),  32'd0);
        chk("midrst_sof",  32'(sof_out), 32'd0);
        chk("midrst_busy", 32'(busy),    32'd0);
        q.delete();
        reset_n = 1'b1;
        watch_idle("post_rst");

        // Degenerate configs never start
        apply_cfg(4'd0, 80'hEB90AA, 4'd0, 48'h5, 8'd1, 1'b0, 8'h00, 4'b0001);
        watch_idle("degen_len");
        apply_cfg(4'd3, 80'hEB90AA, 4'd2, 48'h5, 8'd1, 1'b0, 8'h00, 4'b0000);
        watch_idle("degen_chan");

        chk("final_queue", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
